// File: rtl/rf_sequencer_pkg.sv
// Shared types and constants for the register-file sequencer and its ALU.
package rf_sequencer_pkg;

  localparam int DATA_W  = 16;
  localparam int RADDR_W = 3;
  localparam int IMM_W   = 8;

  typedef enum logic [1:0] {
    OP_MOVI = 2'b00,
    OP_MOV  = 2'b01,
    OP_ADD  = 2'b10,
    OP_AND  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    RDA,
    RDB,
    WB,
    DONE
  } state_e;

  typedef struct packed {
    op_e                op;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] rn;
    logic [RADDR_W-1:0] rm;
    logic [IMM_W-1:0]   imm;
  } cmd_t;

  typedef struct packed {
    logic v;
    logic n;
    logic z;
  } flags_t;

endpackage

// File: rtl/rf_alu.sv
// Combinational datapath: computes the write-back value and {V,N,Z} for one opcode.
module rf_alu
  import rf_sequencer_pkg::*;
(
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] result,
  output flags_t            flags
);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    result  = '0;
    flags.v = 1'b0;
    unique case (op)
      OP_MOVI: result = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      OP_MOV:  result = b;
      OP_ADD: begin
        result  = a + b;
        // Overflow: like-signed operands producing an oppositely-signed sum.
        flags.v = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  result = a & b;
      default: result = '0;
    endcase
    flags.n = result[DATA_W-1];
    flags.z = (result == '0);
  end

endmodule

// File: rtl/rf_sequencer.sv
// Multi-cycle command sequencer: reads up to two operands from an external
// register file, computes through rf_alu, and writes back one result per command.
module rf_sequencer
  import rf_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [RADDR_W-1:0] cmd_rd,
  input  logic [RADDR_W-1:0] cmd_rn,
  input  logic [RADDR_W-1:0] cmd_rm,
  input  logic [IMM_W-1:0]   cmd_imm,
  output logic [RADDR_W-1:0] rf_readnum,
  input  logic [DATA_W-1:0]  rf_rdata,
  output logic [RADDR_W-1:0] rf_writenum,
  output logic               rf_write,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               done,
  output logic [2:0]         flags
);

  state_e            state_q, state_d;
  cmd_t              cmd_q;
  logic [DATA_W-1:0] a_q, b_q;
  flags_t            flags_q;
  logic [DATA_W-1:0] alu_result;
  flags_t            alu_flags;

  rf_alu u_alu (
    .op     (cmd_q.op),
    .a      (a_q),
    .b      (b_q),
    .imm    (cmd_q.imm),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // NOTE: state uses non-blocking assignments and a reset sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      flags_q <= '0;
    end else begin
      if (state_q == IDLE && cmd_valid)
        cmd_q <= '{op: op_e'(cmd_op), rd: cmd_rd, rn: cmd_rn, rm: cmd_rm, imm: cmd_imm};
      if (state_q == RDA) a_q <= rf_rdata;
      if (state_q == RDB) b_q <= rf_rdata;
      if (state_q == WB)  flags_q <= alu_flags;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          unique case (op_e'(cmd_op))
            OP_ADD, OP_AND: state_d = RDA;
            OP_MOV:         state_d = RDB;
            default:        state_d = WB;
          endcase
        end
      end
      RDA:     state_d = RDB;
      RDB:     state_d = WB;
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: only state and latched command/operands feed the register-file port.
  always_comb begin
    cmd_ready   = (state_q == IDLE);
    rf_readnum  = '0;
    rf_write    = 1'b0;
    rf_writenum = '0;
    rf_wdata    = '0;
    done        = 1'b0;
    unique case (state_q)
      RDA: rf_readnum = cmd_q.rn;
      RDB: rf_readnum = cmd_q.rm;
      WB: begin
        rf_write    = 1'b1;
        rf_writenum = cmd_q.rd;
        rf_wdata    = alu_result;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Directed bench for rf_sequencer with a behavioural 8x16 register file.
module tb_rf_sequencer;
  import rf_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
  logic [7:0]  cmd_imm;
  logic [2:0]  rf_readnum, rf_writenum;
  logic [15:0] rf_rdata, rf_wdata;
  logic        rf_write, done;
  logic [2:0]  flags;

  int n_err = 0;
  int n_chk = 0;

  logic [15:0] rf_mem [8] = '{default: '0};
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  always #5 clk = ~clk;

  rf_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rd      (cmd_rd),
    .cmd_rn      (cmd_rn),
    .cmd_rm      (cmd_rm),
    .cmd_imm     (cmd_imm),
    .rf_readnum  (rf_readnum),
    .rf_rdata    (rf_rdata),
    .rf_writenum (rf_writenum),
    .rf_write    (rf_write),
    .rf_wdata    (rf_wdata),
    .done        (done),
    .flags       (flags)
  );

  assign rf_rdata = rf_mem[rf_readnum];

  always @(posedge clk) begin
    if (rf_write)    rf_mem[rf_writenum] <= rf_wdata;
    else if (pre_we) rf_mem[pre_addr]    <= pre_data;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input logic [2:0] addr, input logic [15:0] data);
    pre_we   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    tick();
    pre_we   = 1'b0;
  endtask

  // Presents one command in IDLE; returns at the negedge after the accepting edge.
  task automatic issue(input op_e op, input logic [2:0] rd, rn, rm, input logic [7:0] imm);
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rn    = rn;
    cmd_rm    = rm;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_e         b_op [4] = '{OP_MOV, OP_ADD, OP_MOV, OP_ADD};
    logic [2:0]  b_rd [4] = '{3'd7, 3'd7, 3'd3, 3'd3};
    logic [2:0]  b_rn [4] = '{3'd0, 3'd7, 3'd0, 3'd3};
    logic [2:0]  b_rm [4] = '{3'd2, 3'd2, 3'd7, 3'd0};
    logic [15:0] b_wd [4] = '{16'h0001, 16'h0002, 16'h0002, 16'h8002};
    int          b_lat[4] = '{3, 4, 3, 4};
    int          cycles, writes;
    logic        seen, stray;
    logic [15:0] wd;
    logic [2:0]  wn;

    reset_n = 1'b0; cmd_valid = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_imm = '0;
    tick(); tick();
    check("rst_ready",    16'(cmd_ready),   16'h1);
    check("rst_done",     16'(done),        16'h0);
    check("rst_write",    16'(rf_write),    16'h0);
    check("rst_readnum",  16'(rf_readnum),  16'h0);
    check("rst_writenum", 16'(rf_writenum), 16'h0);
    check("rst_wdata",    rf_wdata,         16'h0);
    check("rst_flags",    16'(flags),       16'h0);
    reset_n = 1'b1;
    tick();
    check("idle_no_valid_ready", 16'(cmd_ready), 16'h1);

    // MOVI R3,#0xF0: WB immediately after accept, done on the second cycle.
    issue(OP_MOVI, 3'd3, 3'd0, 3'd0, 8'hF0);
    check("movi_ready_busy", 16'(cmd_ready),   16'h0);
    check("movi_write",      16'(rf_write),    16'h1);
    check("movi_writenum",   16'(rf_writenum), 16'h3);
    check("movi_wdata",      rf_wdata,         16'hFFF0);
    check("movi_done_early", 16'(done),        16'h0);
    tick();
    check("movi_done",       16'(done),        16'h1);
    check("movi_write_off",  16'(rf_write),    16'h0);
    check("movi_flags",      16'(flags),       16'b010);
    tick();
    check("movi_idle_done",  16'(done),        16'h0);
    check("movi_r3",         rf_mem[3],        16'hFFF0);

    // ADD R0,R1,R2 with signed overflow.
    preload(3'd1, 16'h7FFF);
    preload(3'd2, 16'h0001);
    issue(OP_ADD, 3'd0, 3'd1, 3'd2, 8'h00);
    check("add_rda_readnum", 16'(rf_readnum), 16'h1);
    check("add_rda_write",   16'(rf_write),   16'h0);
    tick();
    check("add_rdb_readnum", 16'(rf_readnum), 16'h2);
    check("add_rdb_done",    16'(done),       16'h0);
    tick();
    check("add_wb_write",    16'(rf_write),    16'h1);
    check("add_wb_writenum", 16'(rf_writenum), 16'h0);
    check("add_wb_wdata",    rf_wdata,         16'h8000);
    check("add_wb_readnum",  16'(rf_readnum),  16'h0);
    tick();
    check("add_done",        16'(done),        16'h1);
    check("add_flags",       16'(flags),       16'b110);
    tick();

    // AND R4,R4,R5: destination aliases an operand, result zero.
    preload(3'd4, 16'h00FF);
    preload(3'd5, 16'hFF00);
    issue(OP_AND, 3'd4, 3'd4, 3'd5, 8'h00);
    tick(); tick();
    check("and_wb_writenum", 16'(rf_writenum), 16'h4);
    check("and_wb_wdata",    rf_wdata,         16'h0000);
    tick();
    check("and_done",        16'(done),        16'h1);
    check("and_flags",       16'(flags),       16'b001);
    check("and_r4",          rf_mem[4],        16'h0000);
    tick();

    // MOV R6,R1: three-cycle path through RDB only.
    issue(OP_MOV, 3'd6, 3'd0, 3'd1, 8'h00);
    check("mov_rdb_readnum", 16'(rf_readnum), 16'h1);
    tick();
    check("mov_wb_wdata",    rf_wdata,        16'h7FFF);
    tick();
    check("mov_done",        16'(done),       16'h1);
    check("mov_flags",       16'(flags),      16'b000);
    tick();

    // cmd_valid held high; fields switch to the next command during DONE.
    cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cmd_op = b_op[k]; cmd_rd = b_rd[k]; cmd_rn = b_rn[k]; cmd_rm = b_rm[k]; cmd_imm = 8'h00;
      cycles = 0; writes = 0; seen = 1'b0; wd = '0; wn = '0;
      while (!seen && cycles < 12) begin
        tick();
        cycles++;
        if (rf_write) begin
          writes++;
          wd = rf_wdata;
          wn = rf_writenum;
        end
        if (done) seen = 1'b1;
      end
      check($sformatf("b2b%0d_latency", k), 16'(cycles), 16'((k == 0) ? b_lat[k] : b_lat[k] + 1));
      check($sformatf("b2b%0d_writes", k),  16'(writes), 16'h1);
      check($sformatf("b2b%0d_wdata", k),   wd,          b_wd[k]);
      check($sformatf("b2b%0d_writenum", k), 16'(wn),    16'(b_rd[k]));
    end
    cmd_valid = 1'b0;
    tick();
    check("b2b_ready_end", 16'(cmd_ready), 16'h1);
    check("b2b_r7",        rf_mem[7],      16'h0002);
    check("b2b_r3",        rf_mem[3],      16'h8002);
    check("b2b_flags",     16'(flags),     16'b010);

    // Reset during RDB of an ADD: no write, no done, flags cleared.
    issue(OP_ADD, 3'd5, 3'd1, 3'd2, 8'h00);
    tick();
    check("rrdb_readnum", 16'(rf_readnum), 16'h2);
    reset_n = 1'b0;
    tick();
    check("rrdb_ready",   16'(cmd_ready),  16'h1);
    check("rrdb_write",   16'(rf_write),   16'h0);
    check("rrdb_done",    16'(done),       16'h0);
    check("rrdb_flags",   16'(flags),      16'h0);
    check("rrdb_readnum0", 16'(rf_readnum), 16'h0);
    reset_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rf_write || done) stray = 1'b1;
    end
    check("rrdb_no_stray", 16'(stray),   16'h0);
    check("rrdb_r5_kept",  rf_mem[5],    16'hFF00);

    // Reset during WB: that write lands, nothing follows.
    issue(OP_MOVI, 3'd2, 3'd0, 3'd0, 8'h05);
    check("rwb_write", 16'(rf_write), 16'h1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rwb_r2",        rf_mem[2],       16'h0005);
    check("rwb_write_off", 16'(rf_write),   16'h0);
    check("rwb_ready",     16'(cmd_ready),  16'h1);
    check("rwb_flags",     16'(flags),      16'h0);
    tick();
    check("rwb_no_done",   16'(done),       16'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
